// File: rtl/data_mem_lsu.sv
// Data-memory stage: word-organised RAM with byte/half/word load-store unit and registered,
// extended load result. Optional misaligned-access trapping via `DMEM_MISALIGN_TRAP_EN.
module data_mem_lsu #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [31:0]       a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              rd_valid,
    output logic              misalign
);
    localparam int DEPTH = 2 ** DM_ADDRESS;

    logic [DATA_W-1:0]     mem_r [0:DEPTH-1];
    logic [DM_ADDRESS-1:0] idx_s;
    logic                  is_byte_s;
    logic                  is_half_s;
    logic                  is_word_s;
    logic                  load_ok_s;
    logic                  store_ok_s;
    logic                  mis_s;
    logic [1:0]            lane_s;
    logic [3:0]            be_s;
    logic [DATA_W-1:0]     wdata_s;
    logic [DATA_W-1:0]     word_s;
    logic [DATA_W-1:0]     shifted_s;
    logic [DATA_W-1:0]     load_data_s;
    logic                  load_req_s;
    logic                  do_store_s;
    logic                  mis_pulse_s;
    logic                  a_unused_s;

    assign idx_s      = a[DM_ADDRESS+1:2];
    assign a_unused_s = ^a[31:DM_ADDRESS+2];

    // Access-size decode, effective lane, byte enables and misalignment
    always_comb begin
        is_byte_s  = 1'b0;
        is_half_s  = 1'b0;
        is_word_s  = 1'b0;
        load_ok_s  = 1'b0;
        store_ok_s = 1'b0;
        case (Funct3)
            3'b000:  begin is_byte_s = 1'b1; load_ok_s = 1'b1; store_ok_s = 1'b1; end
            3'b001:  begin is_half_s = 1'b1; load_ok_s = 1'b1; store_ok_s = 1'b1; end
            3'b010:  begin is_word_s = 1'b1; load_ok_s = 1'b1; store_ok_s = 1'b1; end
            3'b100:  begin is_byte_s = 1'b1; load_ok_s = 1'b1; end
            3'b101:  begin is_half_s = 1'b1; load_ok_s = 1'b1; end
            default: begin is_byte_s = 1'b0; end
        endcase

        // Halfword and word accesses always use the aligned lane; misaligned ones are either
        // suppressed (trap build) or silently forced to alignment.
        if (is_byte_s) begin
            lane_s  = a[1:0];
            be_s    = 4'b0001 << a[1:0];
            wdata_s = {4{wd[7:0]}};
        end else if (is_half_s) begin
            lane_s  = {a[1], 1'b0};
            be_s    = a[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{wd[15:0]}};
        end else begin
            lane_s  = 2'b00;
            be_s    = 4'b1111;
            wdata_s = wd;
        end

`ifdef DMEM_MISALIGN_TRAP_EN
        mis_s = (is_half_s & a[0]) | (is_word_s & (a[1:0] != 2'b00));
`else
        mis_s = 1'b0;
`endif
    end

    assign load_req_s  = MemRead & ~MemWrite;
    assign do_store_s  = MemWrite & store_ok_s & ~mis_s & ~reset;
    assign mis_pulse_s = mis_s & ((MemWrite & store_ok_s) | (load_req_s & load_ok_s));

    // Load path: read word, shift selected lane down, then extend
    always_comb begin
        word_s    = mem_r[idx_s];
        shifted_s = word_s >> {lane_s, 3'b000};
        case (Funct3)
            3'b000:  load_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  load_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b010:  load_data_s = shifted_s;
            3'b100:  load_data_s = {24'd0, shifted_s[7:0]};
            3'b101:  load_data_s = {16'd0, shifted_s[15:0]};
            default: load_data_s = {DATA_W{1'b0}};
        endcase
    end

    // Byte-lane RAM write; contents are not reset
    always_ff @(posedge clk) begin
        if (do_store_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Registered load result and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            rd       <= {DATA_W{1'b0}};
            rd_valid <= 1'b0;
            misalign <= 1'b0;
        end else begin
            rd_valid <= load_req_s & ~mis_s;
            misalign <= mis_pulse_s;
            if (load_req_s && !mis_s) begin
                rd <= load_data_s;
            end
        end
    end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Data-memory stage of the pipelined RISC-V core: a synchronous word-organised RAM with a load/store unit for byte, halfword and word accesses. Load results are sign- or zero-extended and registered, then feed the memory-data input of the writeback result select. Stores use byte-lane writes. Misaligned-access detection can be compiled in or out.

## Interface
- DM_ADDRESS, 9: word-address bits; depth = 2^DM_ADDRESS 32-bit words.
- DATA_W, 32: data width. Only 32 is supported.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  load request this cycle.
- MemWrite  in  1  store request this cycle.
- Funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- a  in  32  byte address. Bits [DM_ADDRESS+1:0] are used; upper bits are ignored.
- wd  in  DATA_W  store data, taken from the low bytes.
- rd  out  DATA_W  registered, extended load result.
- rd_valid  out  1  one-cycle pulse when rd is updated.
- misalign  out  1  one-cycle pulse flagging a misaligned access.

## Operation
- **Reset.** rd = 0, rd_valid = 0, misalign = 0. The RAM contents are not cleared. A store presented in a reset cycle is dropped.
- **Addressing.**
  - Word index = a[DM_ADDRESS+1:2]; lane = a[1:0].
  - Addresses alias every 4·2^DM_ADDRESS bytes.
- **Store (MemWrite=1, MemRead=0).**
  - SB: writes wd[7:0] to byte lane a[1:0].
  - SH: writes wd[15:0] to lanes {a[1],0} and {a[1],1}.
  - SW: writes all four lanes.
  - Unwritten lanes keep their old value.
  - Funct3 100/101/other: no write.
- **Load (MemRead=1, MemWrite=0).** The selected word is read, then lanes are shifted down.
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW returns the word unchanged.
  - Illegal Funct3: rd = 0 and rd_valid = 1.
- **MemRead and MemWrite both high.** Treated as a store only; rd_valid = 0; rd holds its value.
- **Neither asserted.** RAM unchanged; rd holds its value; rd_valid = 0.
- **rd persistence.** rd holds the last completed load result until the next load completes.
- **Misalignment** (only when DMEM_MISALIGN_TRAP_EN is defined):
  - An H/HU access with a[0]=1, or a W access with a[1:0]≠0, is misaligned.
  - A misaligned store writes nothing.
  - A misaligned load does not update rd and gives rd_valid = 0.
  - misalign pulses 1 in the following cycle in both cases.

## Timing
- **Load latency.** Request sampled at edge N; rd and rd_valid are valid during cycle N+1. Back-to-back loads give one result per cycle.
- **Store.** Committed at the sampling edge.
- **Store followed by load.** A load issued in the cycle after a store to the same word returns the new data.
- **Read-during-write.** Not possible within one cycle, because store takes priority.
- **Pulses.** misalign asserts in the same cycle rd_valid would have asserted. rd_valid and misalign are never both 1.
- **Reset priority.** Reset has priority over all requests. Outputs are 0 in the cycle after any reset edge.

## Configuration
- Macro: DMEM_MISALIGN_TRAP_EN.
- **Defined.** Misalignment is detected and the access is suppressed, as described under Operation.
- **Undefined.**
  - misalign is tied to 0.
  - Halfword and word accesses force alignment by ignoring a[0] (H) or a[1:0] (W).
  - All such accesses complete normally, with rd_valid = 1 for loads.

## Test plan
- **Word store and load.** SW wd=0xDEADBEEF at a=0x10, then LW a=0x10 next cycle → rd=0xDEADBEEF with rd_valid=1 one cycle after the LW.
- **Byte extension.** After the store above: LB a=0x13 → 0xFFFFFFDE; LBU a=0x13 → 0x000000DE; LH a=0x10 → 0xFFFFBEEF; LHU a=0x12 → 0x0000DEAD.
- **Partial store.** SB wd=0x55 at a=0x11, then SH wd=0x1234 at a=0x12, then LW a=0x10 → 0x123455EF.
- **Misalignment, macro defined.** LW a=0x11 → misalign=1, rd_valid=0, rd unchanged. SW 0xFFFFFFFF at a=0x12, then LW 0x10 → 0x123455EF (no write occurred).
- **Misalignment, macro undefined.** LW a=0x11 → rd=0x123455EF, misalign=0.
- **Reset and arbitration.**
  - reset=1 together with SW 0 at a=0x10 → rd=0 and rd_valid=0. A subsequent LW 0x10 → 0x123455EF (store dropped).
  - MemRead=MemWrite=1 with SW 0xA5A5A5A5 at 0x20 → rd_valid=0. LW 0x20 → 0xA5A5A5A5.
  - LW at a = 0x20 + 4·2^DM_ADDRESS also returns 0xA5A5A5A5 (aliasing).
